// File: rtl/comparador_pkg.sv
// -----------------------------------------------------------------------------
// comparador_pkg
// Shared definitions for the persistent code comparator:
//   - default parameter constants (DEF_W, DEF_CH, DEF_K, DEF_CW)
//   - run_width(): width of a per-channel run counter able to hold 0..K
//   - chan_lsb():  LSB position of channel c inside a CH*W packed bus
// -----------------------------------------------------------------------------
package comparador_pkg;

    localparam int unsigned DEF_W  = 3;
    localparam int unsigned DEF_CH = 4;
    localparam int unsigned DEF_K  = 2;
    localparam int unsigned DEF_CW = 8;

    // Run counter must represent every value 0..K inclusive.
    function automatic int unsigned run_width(input int unsigned k);
        return $clog2(k + 1);
    endfunction

    // Channel c occupies bits [c*w +: w] of a packed code bus.
    function automatic int unsigned chan_lsb(input int unsigned c, input int unsigned w);
        return c * w;
    endfunction

endpackage

// File: rtl/comparador_canal.sv
// -----------------------------------------------------------------------------
// comparador_canal
// One channel of the persistent comparator: W-bit equality (optionally with a
// per-bit don't-care mask), a saturating run counter of consecutive equal
// samples, and the combinational "match after this sample" flag consumed by
// the top-level output registers.
//
// Optional feature macro: COMP_MASK_EN (adds the mask input; 1 = ignore bit).
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   accept       sample is being accepted this cycle (run counter advances)
//   code_a/b     W-bit codes for this channel
//   mask         W-bit don't-care mask (COMP_MASK_EN only)
//   eq_next      run counter value after this sample equals K
// -----------------------------------------------------------------------------
module comparador_canal
    import comparador_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned K = DEF_K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic [W-1:0] code_a,
    input  logic [W-1:0] code_b,
`ifdef COMP_MASK_EN
    input  logic [W-1:0] mask,
`endif
    output logic         eq_next
);

    localparam int unsigned       RUN_W = run_width(K);
    localparam logic [RUN_W-1:0]  K_RUN = RUN_W'(K);

    logic             raw;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic [RUN_W-1:0] run_upd;

    always_comb begin
`ifdef COMP_MASK_EN
        raw = (((code_a ^ code_b) & ~mask) == '0);
`else
        raw = (code_a == code_b);
`endif
        // Saturate at K so a long run keeps reporting a match.
        if (!raw) begin
            run_upd = '0;
        end else if (run_q == K_RUN) begin
            run_upd = K_RUN;
        end else begin
            run_upd = run_q + RUN_W'(1);
        end
        // Counter only moves on accept; stalls leave a run intact.
        run_d   = accept ? run_upd : run_q;
        eq_next = (run_upd == K_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/comparador_persistente_param.sv
// -----------------------------------------------------------------------------
// comparador_persistente_param
// Registered, parametrised comparator of CH channel pairs of W-bit codes.
// A channel reports eq only after K consecutive equal accepted samples;
// match_all is the AND of eq, and match_cnt saturates counting accepted
// samples whose match_all is 1. Results leave through a single-entry
// valid/ready output stage (1-cycle latency, no skid buffer).
//
// Optional feature macro: COMP_MASK_EN (adds mask port, 1 = ignore bit).
//
// Parameters: W code width, CH channel count, K persistence, CW counter width.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready combinational from out_ready)
//   code_a, code_b      CH*W packed codes, channel c at [c*W +: W]
//   mask                CH*W don't-care mask (COMP_MASK_EN only)
//   clr_cnt             synchronous clear of match_cnt (wins over increment)
//   out_valid/out_ready output handshake
//   eq, match_all       registered per-channel and global match
//   match_cnt           saturating count of fully matching accepts
// -----------------------------------------------------------------------------
module comparador_persistente_param
    import comparador_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CH = DEF_CH,
    parameter int unsigned K  = DEF_K,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CH*W-1:0] code_a,
    input  logic [CH*W-1:0] code_b,
`ifdef COMP_MASK_EN
    input  logic [CH*W-1:0] mask,
`endif
    input  logic          clr_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CH-1:0] eq,
    output logic          match_all,
    output logic [CW-1:0] match_cnt
);

    logic          accept;
    logic [CH-1:0] eq_next;

    logic          out_valid_q, out_valid_d;
    logic [CH-1:0] eq_q, eq_d;
    logic          match_all_q, match_all_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;

    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar c = 0; c < CH; c++) begin : g_canal
        comparador_canal #(
            .W (W),
            .K (K)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .accept  (accept),
            .code_a  (code_a[chan_lsb(c, W) +: W]),
            .code_b  (code_b[chan_lsb(c, W) +: W]),
`ifdef COMP_MASK_EN
            .mask    (mask[chan_lsb(c, W) +: W]),
`endif
            .eq_next (eq_next[c])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        eq_d        = eq_q;
        match_all_d = match_all_q;
        match_cnt_d = match_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            eq_d        = eq_next;
            match_all_d = &eq_next;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr_cnt) begin
            match_cnt_d = '0;
        end else if (accept && (&eq_next) && (match_cnt_q != '1)) begin
            match_cnt_d = match_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            eq_q        <= '0;
            match_all_q <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            eq_q        <= eq_d;
            match_all_q <= match_all_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign eq        = eq_q;
    assign match_all = match_all_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_comparador_persistente_param.sv
// -----------------------------------------------------------------------------
// tb_comparador_persistente_param
// Directed bench for comparador_persistente_param with W=3, CH=4, K=2, CW=2.
// Inputs change #1 after the rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_comparador_persistente_param;

    localparam int unsigned W  = 3;
    localparam int unsigned CH = 4;
    localparam int unsigned K  = 2;
    localparam int unsigned CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [CH*W-1:0] code_a;
    logic [CH*W-1:0] code_b;
`ifdef COMP_MASK_EN
    logic [CH*W-1:0] mask;
`endif
    logic            clr_cnt;
    logic            out_valid;
    logic            out_ready;
    logic [CH-1:0]   eq;
    logic            match_all;
    logic [CW-1:0]   match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // All channels 3'b101.
    localparam logic [CH*W-1:0] EQ_CODE = 12'b101_101_101_101;

    comparador_persistente_param #(
        .W  (W),
        .CH (CH),
        .K  (K),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code_a    (code_a),
        .code_b    (code_b),
`ifdef COMP_MASK_EN
        .mask      (mask),
`endif
        .clr_cnt   (clr_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .match_all (match_all),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted sample (out_ready assumed high by caller).
    task automatic send(input logic [CH*W-1:0] a, input logic [CH*W-1:0] b);
        in_valid = 1'b1;
        code_a   = a;
        code_b   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [CH-1:0] e_eq,
                           input logic e_all, input logic [CW-1:0] e_cnt);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_eq"},    eq,        e_eq);
        chk({tag, "_all"},   match_all, e_all);
        chk({tag, "_cnt"},   match_cnt, e_cnt);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        code_a    = '0;
        code_b    = '0;
`ifdef COMP_MASK_EN
        mask      = '0;
`endif
        clr_cnt   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready",  in_ready,  1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_eq",        eq,        4'b0000);
        chk("rst_all",       match_all, 1'b0);
        chk("rst_cnt",       match_cnt, 2'd0);
        reset = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // Two identical samples: persistence of K=2
        send(EQ_CODE, EQ_CODE);
        chk_res("first", 4'b0000, 1'b0, 2'd0);
        send(EQ_CODE, EQ_CODE);
        chk_res("second", 4'b1111, 1'b1, 2'd1);

        // Run break on channel 2 (a=010, b=011)
        send(12'b101_010_101_101, 12'b101_011_101_101);
        chk_res("break", 4'b1011, 1'b0, 2'd1);
        send(EQ_CODE, EQ_CODE);
        chk_res("rebuild1", 4'b1011, 1'b0, 2'd1);
        send(EQ_CODE, EQ_CODE);
        chk_res("rebuild2", 4'b1111, 1'b1, 2'd2);

        // Result consumed with no new accept: out_valid drops
        tick();
        chk("drain_valid", out_valid, 1'b0);

        // Standalone clear keeps eq
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_only_cnt", match_cnt, 2'd0);
        chk("clr_only_eq",  eq,        4'b1111);

        // Backpressure: accept one, then stall 5 cycles with mismatching codes
        out_ready = 1'b0;
        send(EQ_CODE, EQ_CODE);
        chk_res("bp_first", 4'b1111, 1'b1, 2'd1);
        in_valid = 1'b1;
        code_a   = EQ_CODE;
        code_b   = ~EQ_CODE;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
            chk_res("bp_hold", 4'b1111, 1'b1, 2'd1);
        end
        // Release with equal codes: runs survived the stall
        code_b    = EQ_CODE;
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk_res("bp_release", 4'b1111, 1'b1, 2'd2);

        // Saturation at 2^CW-1 = 3
        send(EQ_CODE, EQ_CODE);
        chk_res("sat1", 4'b1111, 1'b1, 2'd3);
        send(EQ_CODE, EQ_CODE);
        chk_res("sat2", 4'b1111, 1'b1, 2'd3);
        send(EQ_CODE, EQ_CODE);
        chk_res("sat3", 4'b1111, 1'b1, 2'd3);

        // Clear wins over a same-cycle matching accept
        clr_cnt = 1'b1;
        send(EQ_CODE, EQ_CODE);
        clr_cnt = 1'b0;
        chk_res("clr_accept", 4'b1111, 1'b1, 2'd0);
        send(EQ_CODE, EQ_CODE);
        chk_res("post_clr", 4'b1111, 1'b1, 2'd1);

        // Reset mid-stream with a held result and full runs
        reset = 1'b1;
        #1;
        chk("mrst_in_ready", in_ready, 1'b0);
        tick();
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_cnt",   match_cnt, 2'd0);
        chk("mrst_eq",    eq,        4'b0000);
        reset = 1'b0;
        send(EQ_CODE, EQ_CODE);
        chk_res("mrst_first", 4'b0000, 1'b0, 2'd0);
        send(EQ_CODE, EQ_CODE);
        chk_res("mrst_second", 4'b1111, 1'b1, 2'd1);

        // Mask behaviour: a=100, b=101, mask=001 on every channel
`ifdef COMP_MASK_EN
        mask = 12'b001_001_001_001;
        send(12'b100_100_100_100, 12'b101_101_101_101);
        chk_res("mask_eq", 4'b1111, 1'b1, 2'd2);
`else
        send(12'b100_100_100_100, 12'b101_101_101_101);
        chk_res("nomask_ne", 4'b0000, 1'b0, 2'd1);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
